// File: rtl/turn_input_conditioner.sv
// Input front end for the tail-light controller: synchronize, debounce, latch direction, blink tick.
// Optional TICK_PHASE_RESET_EN restarts the tick prescaler whenever the registered mode changes.
module turn_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic hazard_sw,
  input  logic turn_sw,
  input  logic dir_btn,
  output logic hazard,
  output logic turn_left,
  output logic turn_right,
  output logic dir_right,
  output logic step_tick
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Bit 0 = hazard, bit 1 = turn, bit 2 = direction button.
  logic [2:0]    raw;
  logic [2:0]    sync_p0;
  logic [2:0]    sync_p1;
  logic [2:0]    db_p2;
  logic [CW-1:0] cnt_p2 [3];
  logic          dir_p2;

  logic [2:0]    db_nxt;
  logic [CW-1:0] cnt_nxt [3];
  logic          dir_rise;
  logic [2:0]    mode_nxt;
  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign raw = {dir_btn, turn_sw, hazard_sw};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    db_nxt = db_p2;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != db_p2[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          db_nxt[i] = sync_p1[i];
        end else begin
          cnt_nxt[i] = cnt_p2[i] + CW'(1);
        end
      end
    end
  end

  // The toggle rides on the debounce edge itself so dir_right lines up with the turn outputs.
  assign dir_rise = db_nxt[2] & ~db_p2[2];

  // Stage p2: debounced levels and latched direction
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      db_p2  <= '0;
      dir_p2 <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      db_p2  <= db_nxt;
      dir_p2 <= dir_p2 ^ dir_rise;
      for (int i = 0; i < 3; i++) begin
        cnt_p2[i] <= cnt_nxt[i];
      end
    end
  end

  assign mode_nxt = {db_p2[0],
                     db_p2[1] & ~dir_p2 & ~db_p2[0],
                     db_p2[1] &  dir_p2 & ~db_p2[0]};

  // Output register: hazard masks both turn requests
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hazard     <= 1'b0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      dir_right  <= 1'b0;
    end else begin
      hazard     <= mode_nxt[2];
      turn_left  <= mode_nxt[1];
      turn_right <= mode_nxt[0];
      dir_right  <= dir_p2;
    end
  end

  assign presc_wrap = (presc == PRESC_MAX);

  // Blink prescaler and registered tick pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc     <= '0;
      step_tick <= 1'b0;
    end else begin
`ifdef TICK_PHASE_RESET_EN
      if (mode_nxt != {hazard, turn_left, turn_right}) begin
        presc     <= '0;
        step_tick <= 1'b0;
      end else begin
        presc     <= presc_wrap ? '0 : presc + PW'(1);
        step_tick <= presc_wrap;
      end
`else
      presc     <= presc_wrap ? '0 : presc + PW'(1);
      step_tick <= presc_wrap;
`endif
    end
  end

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed plus randomized bench for turn_input_conditioner against a cycle-level behavioural model.
module tb_turn_input_conditioner;

  localparam int DC = 4;
  localparam int TD = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic hazard_sw = 1'b0;
  logic turn_sw = 1'b0;
  logic dir_btn = 1'b0;
  logic hazard, turn_left, turn_right, dir_right, step_tick;

  always #5 clock = ~clock;

  turn_input_conditioner #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
    .clock(clock), .reset_n(reset_n),
    .hazard_sw(hazard_sw), .turn_sw(turn_sw), .dir_btn(dir_btn),
    .hazard(hazard), .turn_left(turn_left), .turn_right(turn_right),
    .dir_right(dir_right), .step_tick(step_tick)
  );

  int total = 0;
  int bad = 0;

  // Model state: raw history, synchronized-sample window, stable levels, expected outputs.
  int         k = 0;
  int         phase = 0;
  logic [2:0] raw_q[$];
  logic [2:0] samp_q[$];
  logic [2:0] m_db = '0;
  logic       m_dir = 1'b0;
  logic       m_h = 1'b0, m_l = 1'b0, m_r = 1'b0, m_d = 1'b0, m_tick = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] raw, samp, db_new;
    logic nh, nl, nr;
    raw = {dir_btn, turn_sw, hazard_sw};
    if (!reset_n) begin
      k = 0; phase = 0;
      m_db = '0; m_dir = 1'b0;
      m_h = 1'b0; m_l = 1'b0; m_r = 1'b0; m_d = 1'b0; m_tick = 1'b0;
      samp_q.delete();
    end else begin
      k++;
      nh = m_db[0];
      nl = m_db[1] & ~m_dir & ~m_db[0];
      nr = m_db[1] &  m_dir & ~m_db[0];
      phase = (phase + 1) % TD;
      m_tick = (phase == 0);
`ifdef TICK_PHASE_RESET_EN
      if ({nh, nl, nr} != {m_h, m_l, m_r}) begin
        phase = 0;
        m_tick = 1'b0;
      end
`endif
      m_h = nh; m_l = nl; m_r = nr; m_d = m_dir;
      // A raw level reaches the debouncer two edges later; reset empties that path.
      samp = (k >= 3) ? raw_q[raw_q.size() - 2] : 3'b000;
      samp_q.push_back(samp);
      if (samp_q.size() > DC) void'(samp_q.pop_front());
      db_new = m_db;
      if (samp_q.size() == DC) begin
        for (int i = 0; i < 3; i++) begin
          logic all_same;
          all_same = 1'b1;
          foreach (samp_q[j]) if (samp_q[j][i] != samp[i]) all_same = 1'b0;
          if (all_same) db_new[i] = samp[i];
        end
      end
      if (db_new[2] && !m_db[2]) m_dir = ~m_dir;
      m_db = db_new;
    end
    raw_q.push_back(raw);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("hazard", hazard, m_h);
    chk("turn_left", turn_left, m_l);
    chk("turn_right", turn_right, m_r);
    chk("dir_right", dir_right, m_d);
    chk("step_tick", step_tick, m_tick);
  endtask

  // which: 0 = hazard, 1 = turn_left, 2 = dir_right, 3 = turn_right
  task automatic measure(input string tag, input int which, input int exp_lat);
    int lat;
    logic v;
    lat = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      case (which)
        0: v = hazard;
        1: v = turn_left;
        2: v = dir_right;
        default: v = turn_right;
      endcase
      if (v === 1'b1 && lat < 0) lat = i;
    end
    chk_int(tag, lat, exp_lat);
  endtask

  initial begin
    int pulses, last;
    // Reset with switches active, then release
    reset_n = 1'b0; hazard_sw = 1'b1; turn_sw = 1'b1; dir_btn = 1'b0;
    repeat (5) step();
    reset_n = 1'b1;
    measure("hazard_latency", 0, DC + 3);

    hazard_sw = 1'b0; turn_sw = 1'b0;
    repeat (10) step();

    // Short glitch must be rejected, long level accepted
    turn_sw = 1'b1;
    repeat (2) step();
    turn_sw = 1'b0;
    repeat (10) step();
    chk("glitch_rejected", turn_left, 1'b0);
    turn_sw = 1'b1;
    measure("turn_left_latency", 1, DC + 3);

    // Direction toggle, held button, second press
    dir_btn = 1'b1;
    measure("dir_latency", 2, DC + 3);
    repeat (5) step();
    chk("dir_held_no_retoggle", dir_right, 1'b1);
    dir_btn = 1'b0;
    repeat (10) step();
    dir_btn = 1'b1;
    repeat (10) step();
    chk("second_press_left", turn_left, 1'b1);
    dir_btn = 1'b0;
    repeat (10) step();
    dir_btn = 1'b1;
    repeat (10) step();
    dir_btn = 1'b0;
    repeat (10) step();

    // Hazard priority over an active right turn
    hazard_sw = 1'b1;
    repeat (10) step();
    chk("hazard_masks_right", turn_right, 1'b0);
    hazard_sw = 1'b0;
    measure("right_restored", 3, DC + 3);

    // Reset in the middle of a hazard debounce
    hazard_sw = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    measure("hazard_after_midreset", 0, DC + 3);

    // Tick spacing with a stable mode
    repeat (5) step();
    pulses = 0; last = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (step_tick === 1'b1) begin
        if (last >= 0) chk_int("tick_gap", i - last, TD);
        last = i;
        pulses++;
      end
    end
    chk_int("tick_count", pulses, 100 / TD);

    // Randomized input segments with occasional resets
    for (int s = 0; s < 45; s++) begin
      hazard_sw = 1'($urandom_range(0, 3) == 0);
      turn_sw   = 1'($urandom_range(0, 1));
      dir_btn   = 1'($urandom_range(0, 1));
      reset_n   = ($urandom_range(0, 19) != 0);
      repeat ($urandom_range(1, 8)) step();
      reset_n = 1'b1;
    end
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
